fht_but_pipe: RTL and testbench

//  Parametrised, pipelined 2-point FHT butterfly; next generation of the single-stage fht_but.
//  y0/y1 = x0 +/- (cos*x1 + sin*x2), with per-sample runtime /2 scaling, rounding and saturation.

---
 rtl/fht_pkg.sv | 41 ++++
 rtl/fht_rot_mac.sv | 74 +++++++
 rtl/fht_but_pipe.sv | 114 +++++++++++
 tb/tb_fht_but_pipe.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fht_pkg.sv
// Shared types and arithmetic helpers for the FHT butterfly datapath.
// Helpers work on a 64-bit signed carrier so every stage width can reuse them.
package fht_pkg;

   typedef logic signed [63:0] wide_t;

   // Control bits that travel alongside a sample through S1 and S2
   typedef struct packed {
      logic valid;
      logic scale;
   } s1_t;

   typedef struct packed {
      logic valid;
      logic scale;
   } s2_t;

   // Coefficient value representing 1.0
   function automatic int unity(input int w_bit);
      return 1 << (w_bit - 2);
   endfunction

   // Arithmetic shift right by sh with round-half-up
   function automatic wide_t round_shift(input wide_t v, input int sh);
      wide_t half;
      half = 64'sd1 <<< (sh - 1);
      return (v + half) >>> sh;
   endfunction

   // Clamp to the two's complement range of a d_bit-wide word
   function automatic wide_t sat_d(input wide_t v, input int d_bit);
      wide_t hi;
      wide_t lo;
      hi = (64'sd1 <<< (d_bit - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (d_bit - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/fht_rot_mac.sv
// Rotation MAC: S1 registers cos*x1 and sin*x2, S2 registers their rounded sum.
// Also carries valid/scale so the caller only adds its own final stage.
module fht_rot_mac
   import fht_pkg::*;
#(
   parameter int D_BIT = 16,
   parameter int W_BIT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             valid,
   input  logic             scale,
   input  logic [D_BIT-1:0] x1,
   input  logic [D_BIT-1:0] x2,
   input  logic [W_BIT-1:0] sin_c,
   input  logic [W_BIT-1:0] cos_c,
   output logic [D_BIT+2:0] rot,
   output logic             rot_valid,
   output logic             rot_scale
);

   localparam int PW    = D_BIT + W_BIT;
   localparam int UNITY = unity(W_BIT);
   localparam int RSH   = $clog2(UNITY);

   typedef logic signed [PW-1:0]    prod_t;
   typedef logic signed [D_BIT+2:0] rot_t;

   prod_t p1_d, p1_q, p2_d, p2_q;
   s1_t   s1_d, s1_q;
   s2_t   s2_d, s2_q;
   rot_t  rot_d, rot_q;
   wide_t sum_w;

   always_comb begin
      p1_d  = p1_q;
      p2_d  = p2_q;
      s1_d  = s1_q;
      rot_d = rot_q;
      s2_d  = s2_q;
      sum_w = wide_t'(p1_q) + wide_t'(p2_q);
      if (en) begin
         p1_d       = prod_t'($signed(cos_c)) * prod_t'($signed(x1));
         p2_d       = prod_t'($signed(sin_c)) * prod_t'($signed(x2));
         s1_d.valid = valid;
         s1_d.scale = scale;
         // D_BIT+3 bits covers the -1.0 * most-negative-x corner
         rot_d      = rot_t'(round_shift(sum_w, RSH));
         s2_d       = s2_t'(s1_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p1_q  <= '0;
         p2_q  <= '0;
         s1_q  <= '0;
         rot_q <= '0;
         s2_q  <= '0;
      end else begin
         p1_q  <= p1_d;
         p2_q  <= p2_d;
         s1_q  <= s1_d;
         rot_q <= rot_d;
         s2_q  <= s2_d;
      end
   end

   assign rot       = rot_q;
   assign rot_valid = s2_q.valid;
   assign rot_scale = s2_q.scale;

endmodule

// File: rtl/fht_but_pipe.sv
// Pipelined 2-point FHT butterfly: y0/y1 = x0 +/- (cos*x1 + sin*x2), 3 enabled cycles.
// Adds x0 alignment, optional /2 scaling, saturation and overflow flags on top of fht_rot_mac.
module fht_but_pipe
   import fht_pkg::*;
#(
   parameter int D_BIT  = 16,
   parameter int W_BIT  = 16,
   parameter int X0_LAG = 1
) (
   input  logic             iCLK,
   input  logic             iRESET,
   input  logic             iEN,
   input  logic             iVALID,
   input  logic             iSCALE,
   input  logic [D_BIT-1:0] iX_0,
   input  logic [D_BIT-1:0] iX_1,
   input  logic [D_BIT-1:0] iX_2,
   input  logic [W_BIT-1:0] iSIN,
   input  logic [W_BIT-1:0] iCOS,
   input  logic             iCLR_OVF,
   output logic [D_BIT-1:0] oY_0,
   output logic [D_BIT-1:0] oY_1,
   output logic             oVALID,
   output logic             oOVF,
   output logic             oOVF_STKY
);

   typedef logic signed [D_BIT-1:0] dat_t;
   typedef logic signed [D_BIT+2:0] rot_t;
   typedef logic signed [D_BIT+3:0] sum_t;

   rot_t  rot_s;
   logic  rot_valid, rot_scale;
   dat_t  x0_s1_d, x0_s1_q, x0_s2_d, x0_s2_q;
   dat_t  y0_d, y0_q, y1_d, y1_q;
   logic  valid_d, valid_q, ovf_d, ovf_q, stky_d, stky_q;
   sum_t  s0, s1;
   wide_t y0_w, y1_w;
   logic  clip0, clip1;

   fht_rot_mac #(.D_BIT(D_BIT), .W_BIT(W_BIT)) u_rot_mac (
      .clk       (iCLK),
      .rst       (iRESET),
      .en        (iEN),
      .valid     (iVALID),
      .scale     (iSCALE),
      .x1        (iX_1),
      .x2        (iX_2),
      .sin_c     (iSIN),
      .cos_c     (iCOS),
      .rot       (rot_s),
      .rot_valid (rot_valid),
      .rot_scale (rot_scale)
   );

   always_comb begin
      x0_s1_d = x0_s1_q;
      x0_s2_d = x0_s2_q;
      y0_d    = y0_q;
      y1_d    = y1_q;
      valid_d = valid_q;
      ovf_d   = ovf_q;
      stky_d  = stky_q;
      s0      = sum_t'(x0_s2_q) + sum_t'(rot_s);
      s1      = sum_t'(x0_s2_q) - sum_t'(rot_s);
      if (rot_scale) begin
         s0 = sum_t'(round_shift(wide_t'(s0), 1));
         s1 = sum_t'(round_shift(wide_t'(s1), 1));
      end
      y0_w  = sat_d(wide_t'(s0), D_BIT);
      y1_w  = sat_d(wide_t'(s1), D_BIT);
      clip0 = (y0_w != wide_t'(s0));
      clip1 = (y1_w != wide_t'(s1));
      if (iEN) begin
         x0_s1_d = dat_t'(iX_0);
         // With lag, x0 arrives one enabled cycle after its coefficients and skips S1
         x0_s2_d = (X0_LAG != 0) ? dat_t'(iX_0) : x0_s1_q;
         valid_d = rot_valid;
         ovf_d   = rot_valid & (clip0 | clip1);
         if (rot_valid) begin
            y0_d = dat_t'(y0_w);
            y1_d = dat_t'(y1_w);
         end
         stky_d = ovf_d | (stky_q & ~iCLR_OVF);
      end
   end

   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         x0_s1_q <= '0;
         x0_s2_q <= '0;
         y0_q    <= '0;
         y1_q    <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         stky_q  <= 1'b0;
      end else begin
         x0_s1_q <= x0_s1_d;
         x0_s2_q <= x0_s2_d;
         y0_q    <= y0_d;
         y1_q    <= y1_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
         stky_q  <= stky_d;
      end
   end

   assign oY_0      = y0_q;
   assign oY_1      = y1_q;
   assign oVALID    = valid_q;
   assign oOVF      = ovf_q;
   assign oOVF_STKY = stky_q;

endmodule

// File: tb/tb_fht_but_pipe.sv
// Directed bench for fht_but_pipe: dut_a uses X0_LAG=1, dut_b X0_LAG=0; both must match the same expectations.
module tb_fht_but_pipe;

   logic        clk = 1'b0;
   logic        rst, en, valid, scale, clr;
   logic [15:0] x0_now, x0_lag, x1, x2, sn, cs;
   logic [15:0] y0_a, y1_a, y0_b, y1_b;
   logic        vld_a, ovf_a, stk_a, vld_b, ovf_b, stk_b;
   int          checks = 0;
   int          errors = 0;
   int          pend_x0 = 0;

   // Test 4 vectors and their hand-computed results
   int tv_x0[8]  = '{100, 0, 10, 10, 5, -5, -30000, 7};
   int tv_x1[8]  = '{200, 0, 3, -3, 0, 0, 10000, 1};
   int tv_x2[8]  = '{0, 300, 0, 0, 0, 0, 0, 1};
   int tv_c[8]   = '{16384, 0, 8192, 8192, 0, 0, 16384, -16384};
   int tv_s[8]   = '{0, 16384, 0, 0, 0, 0, 0, 16384};
   int tv_sc[8]  = '{0, 0, 0, 0, 1, 1, 0, 0};
   int ex_y0[8]  = '{300, 300, 12, 9, 3, -2, -20000, 7};
   int ex_y1[8]  = '{-100, -300, 8, 11, 3, -2, -32768, 7};
   int ex_ovf[8] = '{0, 0, 0, 0, 0, 0, 1, 0};

   always #5 clk = ~clk;

   fht_but_pipe #(.D_BIT(16), .W_BIT(16), .X0_LAG(1)) dut_a (
      .iCLK(clk), .iRESET(rst), .iEN(en), .iVALID(valid), .iSCALE(scale),
      .iX_0(x0_lag), .iX_1(x1), .iX_2(x2), .iSIN(sn), .iCOS(cs), .iCLR_OVF(clr),
      .oY_0(y0_a), .oY_1(y1_a), .oVALID(vld_a), .oOVF(ovf_a), .oOVF_STKY(stk_a)
   );

   fht_but_pipe #(.D_BIT(16), .W_BIT(16), .X0_LAG(0)) dut_b (
      .iCLK(clk), .iRESET(rst), .iEN(en), .iVALID(valid), .iSCALE(scale),
      .iX_0(x0_now), .iX_1(x1), .iX_2(x2), .iSIN(sn), .iCOS(cs), .iCLR_OVF(clr),
      .oY_0(y0_b), .oY_1(y1_b), .oVALID(vld_b), .oOVF(ovf_b), .oOVF_STKY(stk_b)
   );

   function automatic int sx(input logic [15:0] v);
      return int'($signed(v));
   endfunction

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_out(input string tag, input int ey0, input int ey1,
                            input int ev, input int eo, input int es);
      check({tag, "_a_y0"}, sx(y0_a), ey0);
      check({tag, "_a_y1"}, sx(y1_a), ey1);
      check({tag, "_a_vld"}, int'(vld_a), ev);
      check({tag, "_a_ovf"}, int'(ovf_a), eo);
      check({tag, "_a_stky"}, int'(stk_a), es);
      check({tag, "_b_y0"}, sx(y0_b), ey0);
      check({tag, "_b_y1"}, sx(y1_b), ey1);
      check({tag, "_b_vld"}, int'(vld_b), ev);
      check({tag, "_b_ovf"}, int'(ovf_b), eo);
      check({tag, "_b_stky"}, int'(stk_b), es);
   endtask

   // Drives one cycle at the falling edge; the lagged x0 follows one enabled cycle behind
   task automatic drive(input logic v, input int a0, input int a1, input int a2,
                        input int c, input int s, input logic sc, input logic e,
                        input logic cl);
      @(negedge clk);
      valid  = v;
      x0_now = 16'(a0);
      x0_lag = e ? 16'(pend_x0) : 16'h5a5a;
      x1     = 16'(a1);
      x2     = 16'(a2);
      cs     = 16'(c);
      sn     = 16'(s);
      scale  = sc;
      en     = e;
      clr    = cl;
      if (e) pend_x0 = v ? a0 : 0;
   endtask

   task automatic bub();
      drive(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic bub_clr();
      drive(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic drive_v(input int i, input logic e);
      drive(1'b1, tv_x0[i], tv_x1[i], tv_x2[i], tv_c[i], tv_s[i], tv_sc[i] != 0, e, 1'b0);
   endtask

   task automatic chk_v(input string tag, input int i);
      check_out(tag, ex_y0[i], ex_y1[i], 1, ex_ovf[i], (i >= 6) ? 1 : 0);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; valid = 1'b0; scale = 1'b0; clr = 1'b0;
      x0_now = '0; x0_lag = '0; x1 = '0; x2 = '0; sn = '0; cs = '0;
      bub();
      bub();
      check_out("reset", 0, 0, 0, 0, 0);
      rst = 1'b0;

      // Test 1: scaled pass-through rotation, latency check
      drive(1'b1, 1000, 2000, 0, 16384, 0, 1'b1, 1'b1, 1'b0);
      bub();
      bub();
      check_out("t1_early", 0, 0, 0, 0, 0);
      bub();
      check_out("t1", 1500, -500, 1, 0, 0);

      // Test 2: positive saturation on y0
      drive(1'b1, 32767, 32767, 32767, 11585, 11585, 1'b0, 1'b1, 1'b0);
      bub();
      bub();
      bub();
      check_out("t2", 32767, -13572, 1, 1, 1);
      bub();
      check_out("t2_bubble", 32767, -13572, 0, 0, 1);
      bub_clr();
      bub();
      check_out("clr", 32767, -13572, 0, 0, 0);

      // Test 3: cos = -1.0 with most-negative x1
      drive(1'b1, 0, -32768, 0, -16384, 0, 1'b1, 1'b1, 1'b0);
      bub();
      bub();
      bub();
      check_out("t3", 16384, -16384, 1, 0, 0);

      // Test 4: back-to-back stream with a two-cycle enable gap holding sample 4
      drive_v(0, 1'b1);
      drive_v(1, 1'b1);
      drive_v(2, 1'b1);
      drive_v(3, 1'b1);
      chk_v("t4_s0", 0);
      drive_v(4, 1'b0);
      chk_v("t4_s1", 1);
      drive_v(4, 1'b0);
      chk_v("t4_frz1", 1);
      drive_v(4, 1'b1);
      chk_v("t4_frz2", 1);
      drive_v(5, 1'b1);
      chk_v("t4_s2", 2);
      drive_v(6, 1'b1);
      chk_v("t4_s3", 3);
      drive_v(7, 1'b1);
      chk_v("t4_s4", 4);
      bub();
      chk_v("t4_s5", 5);
      bub();
      chk_v("t4_s6", 6);
      bub();
      chk_v("t4_s7", 7);

      // Test 5: asynchronous reset with two samples in flight
      drive(1'b1, 1000, 2000, 0, 16384, 0, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 0, -32768, 0, -16384, 0, 1'b1, 1'b1, 1'b0);
      bub();
      #1 rst = 1'b1;
      #1 check_out("t5_async", 0, 0, 0, 0, 0);
      bub();
      bub();
      rst = 1'b0;
      drive(1'b1, 1000, 2000, 0, 16384, 0, 1'b1, 1'b1, 1'b0);
      bub();
      check_out("t5_flush1", 0, 0, 0, 0, 0);
      bub();
      check_out("t5_flush2", 0, 0, 0, 0, 0);
      bub();
      check_out("t5_after", 1500, -500, 1, 0, 0);

      // Test 6: clear coinciding with an overflowing output, then a plain clear
      drive(1'b1, 32767, 32767, 32767, 11585, 11585, 1'b0, 1'b1, 1'b0);
      bub();
      bub_clr();
      bub_clr();
      check_out("t6_set_wins", 32767, -13572, 1, 1, 1);
      bub();
      check_out("t6_cleared", 32767, -13572, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
